// File: rtl/tt_um_sumador_serie.sv
// Bit-serial adder: one full-adder cell walks two WIDTH-bit operands LSB first.
// Optional subtraction mode is compiled in with `define SUMADOR_SERIE_SUB_EN.

module sumador_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module tt_um_sumador_serie #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, sum_sh_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;

  logic load_a_w, load_b_w, start_w, cin_w;
  assign load_a_w = uio_in[0];
  assign load_b_w = uio_in[1];
  assign start_w  = uio_in[2];
  assign cin_w    = uio_in[3];

  logic fa_b_w, fa_s_w, carry_d;
  logic [WIDTH-1:0] sum_d;
  logic last_w;
  logic carry_init_w;

`ifdef SUMADOR_SERIE_SUB_EN
  logic sub_q;
  assign fa_b_w       = op_b_q[0] ^ sub_q;
  assign carry_init_w = uio_in[4] | cin_w;
`else
  assign fa_b_w       = op_b_q[0];
  assign carry_init_w = cin_w;
`endif

  sumador_fa_cell u_fa (
    .a_i (op_a_q[0]),
    .b_i (fa_b_w),
    .c_i (carry_q),
    .s_o (fa_s_w),
    .c_o (carry_d)
  );

  // New sum bit enters at the MSB so the LSB-first result ends up aligned.
  assign sum_d  = WIDTH'({fa_s_w, sum_sh_q} >> 1);
  assign last_w = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sum_sh_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SUMADOR_SERIE_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (load_a_w || load_b_w) begin
            if (load_a_w) op_a_q <= ui_in[WIDTH-1:0];
            if (load_b_w) op_b_q <= ui_in[WIDTH-1:0];
          end else if (start_w) begin
            state_q  <= RUN;
            carry_q  <= carry_init_w;
            cnt_q    <= '0;
            sum_sh_q <= '0;
`ifdef SUMADOR_SERIE_SUB_EN
            sub_q    <= uio_in[4];
`endif
          end
        end
        RUN: begin
          op_a_q   <= op_a_q >> 1;
          op_b_q   <= op_b_q >> 1;
          sum_sh_q <= sum_d;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_w) begin
            state_q  <= DONE;
            result_q <= sum_d;
            cout_q   <= carry_d;
            // carry_q here is the carry into the MSB stage
            ovf_q    <= carry_q ^ carry_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uo_out  = 8'(result_q);
  assign uio_out = {ovf_q, cout_q, (state_q == DONE), (state_q == RUN), 4'b0000};
  assign uio_oe  = 8'hF0;

  logic unused_w;
  assign unused_w = &{1'b0, ena, ui_in, uio_in};
endmodule

// File: tb/tb_tt_um_sumador_serie.sv
// Self-checking bench for tt_um_sumador_serie: vector table, corner sequences, random ops vs model.
module tb_tt_um_sumador_serie;
  localparam int W = 8;
`ifdef SUMADOR_SERIE_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = '0, uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_sumador_serie #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] res;
    logic       cout, ovf;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole words.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                input logic sub, output logic [7:0] res, output logic co,
                                output logic ov);
    logic [8:0] s;
    logic [7:0] bm;
    logic       c0;
    bm  = (SUB_EN && sub) ? ~b : b;
    c0  = (SUB_EN && sub) ? 1'b1 : cin;
    s   = {1'b0, a} + {1'b0, bm} + 9'(c0);
    res = s[7:0];
    co  = s[8];
    ov  = (a[7] == bm[7]) && (res[7] != a[7]);
  endfunction

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk); ui_in = a; uio_in = 8'h01;
    @(negedge clk); ui_in = b; uio_in = 8'h02;
    @(negedge clk); uio_in = 8'h00;
  endtask

  task automatic start_op(input logic cin, input logic sub);
    uio_in = {3'b000, sub, cin, 3'b100};
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  // Entered at the negedge right after a busy cycle has begun.
  task automatic wait_done(input string tag, input int exp_busy, output logic [7:0] res,
                           output logic co, output logic ov);
    int nb;
    nb = 0;
    while (uio_out[4] && nb < 4 * W) begin
      nb++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, nb, exp_busy);
    chk({tag, " done_high"}, uio_out[5], 1);
    res = uo_out; co = uio_out[6]; ov = uio_out[7];
    @(negedge clk);
    chk({tag, " done_pulse"}, uio_out[5], 0);
  endtask

  task automatic run_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub, input logic [7:0] er,
                           input logic ec, input logic eo);
    logic [7:0] r;
    logic       c, o;
    load_ops(a, b);
    start_op(cin, sub);
    wait_done(tag, W, r, c, o);
    chk({tag, " result"}, r, er);
    chk({tag, " cout"}, c, ec);
    chk({tag, " ovf"}, o, eo);
  endtask

  initial begin
    logic [7:0] r, er, a, b;
    logic       c, o, ec, eo, ci, sb;
    int         extra;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
`ifdef SUMADOR_SERIE_SUB_EN
    tbl[4] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
`else
    tbl[4] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
`endif

    #2;
    chk("reset uo_out", uo_out, 8'h00);
    chk("reset uio_out", uio_out, 8'h00);
    chk("reset uio_oe", uio_oe, 8'hF0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i])
      run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                tbl[i].res, tbl[i].cout, tbl[i].ovf);

    // Loads and start while busy must be ignored, and no extra op may follow.
    load_ops(8'h5A, 8'h3C);
    start_op(1'b0, 1'b0);
    ui_in = 8'h11; uio_in = 8'h01;
    @(negedge clk); uio_in = 8'h00;
    @(negedge clk); uio_in = 8'h0C;
    @(negedge clk); uio_in = 8'h00;
    wait_done("busy_ign", W - 3, r, c, o);
    chk("busy_ign result", r, 8'h96);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (uio_out[4] || uio_out[5]) extra++;
    end
    chk("busy_ign no_retrigger", extra, 0);
    chk("busy_ign held", uo_out, 8'h96);

    // Asynchronous reset in the 4th busy cycle.
    load_ops(8'h5A, 8'h3C);
    start_op(1'b0, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("midrun busy_before", uio_out[4], 1);
    rst_n = 1'b0;
    #1;
    chk("midrun uo_out", uo_out, 8'h00);
    chk("midrun uio_out", uio_out, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    run_check("after_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    // Load wins over start in the same IDLE cycle.
    @(negedge clk); ui_in = 8'h11; uio_in = 8'h02;
    @(negedge clk); ui_in = 8'h22; uio_in = 8'h05;
    @(negedge clk); uio_in = 8'h00;
    chk("ld_start busy", uio_out[4], 0);
    start_op(1'b0, 1'b0);
    wait_done("ld_start", W, r, c, o);
    chk("ld_start result", r, 8'h33);

    for (int n = 0; n < 40; n++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      model(a, b, ci, sb, er, ec, eo);
      run_check($sformatf("rnd%0d", n), a, b, ci, sb, er, ec, eo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_um_sumador_serie.md
# tt_um_sumador_serie

Bit-serial adder controller for the Tiny Tapeout tile. It sequences a single one-bit full-adder cell over two WIDTH-bit operands, LSB first, with one bit per clock. It holds the running carry between cycles and presents the assembled sum, carry-out and signed overflow flag with a start/busy/done handshake. It lets the team's one-bit adder datapath perform multi-bit additions without widening the combinational logic.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range 1..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  tile enable; ignored.
- ui_in  in  8  operand data bus; bits [WIDTH-1:0] are used.
- uio_in  in  8  controls: [0] load_a, [1] load_b, [2] start, [3] cin, [4] sub (see Configuration); [7:5] ignored.
- uo_out  out  8  result register; bits [7:WIDTH] are tied 0.
- uio_out  out  8  status: [4] busy, [5] done, [6] cout, [7] ovf; [3:0] tied 0.
- uio_oe  out  8  constant 8'hF0, independent of reset.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset places it in IDLE.
- Registers:
  - op_a and op_b: WIDTH-bit shift registers.
  - sum_sh: WIDTH-bit shift register.
  - carry and prev_carry: 1 bit each.
  - bit counter: 0..WIDTH-1.
  - result: WIDTH bits.
  - cout_r and ovf_r: 1 bit each.
- Behaviour in IDLE:
  - load_a=1 copies ui_in[WIDTH-1:0] into op_a. load_b=1 copies it into op_b. Both may load in the same cycle.
  - If any load is high, start is ignored in that cycle (load has priority).
  - start=1 with no load moves the FSM to RUN, sets carry=cin, clears the counter and clears sum_sh.
- Behaviour in RUN, once per edge:
  - The full-adder inputs are op_a[0], op_b[0] and carry.
  - The sum bit is shifted into sum_sh at the MSB. op_a and op_b shift right.
  - carry takes the full-adder carry; prev_carry takes the old carry.
  - The counter increments.
- Leaving RUN: on the edge that processes bit WIDTH-1:
  - the FSM moves to DONE;
  - result takes the final sum;
  - cout_r takes the final carry;
  - ovf_r = (carry into MSB) XOR (carry out of MSB).
- DONE lasts one cycle, then the FSM returns to IDLE.
- Held values: result, cout_r and ovf_r hold until the next completed operation. uo_out never shows a partial sum.
- Ignored inputs:
  - In RUN and DONE, load_a, load_b, start and cin are ignored.
  - op_a and op_b contents after an operation are undefined. Software reloads both operands before each start.
- Output status bits: busy = (state==RUN); done = (state==DONE); cout = cout_r; ovf = ovf_r.
- Reset: asserting rst_n at any time, including mid-RUN, immediately clears all registers and outputs and returns the FSM to IDLE. No partial result survives.
- Reset values: uo_out=0x00, uio_out=0x00, uio_oe=0xF0.

## Timing
- start is sampled at edge k while in IDLE.
- busy is high after edges k through k+WIDTH-1, i.e. WIDTH cycles.
- Bit i is processed at edge k+1+i.
- done, result, cout and ovf update at edge k+WIDTH.
- done is a single-cycle pulse.
- The earliest next start is sampled at edge k+WIDTH+1 (while done is high the FSM is in DONE, so start is ignored).
- Throughput: one operation per WIDTH+1 cycles, plus operand-load cycles.
- start held high continuously re-triggers on every IDLE cycle.

## Configuration
- Macro: SUMADOR_SERIE_SUB_EN.
- Defined: uio_in[4] (sub) is sampled with start. When sub=1:
  - op_b is bitwise-inverted at each full-adder input;
  - carry is initialised to 1 and cin is ignored;
  - cout=1 means no borrow;
  - ovf follows the signed-subtraction rule.
- Not defined: uio_in[4] is ignored and the block performs addition only.

## Test plan
- Load A=0x5A, B=0x3C, cin=0, start → after 8 busy cycles, done pulses once, uo_out=0x96, cout=0, ovf=1.
- A=0xFF, B=0x01, cin=0 → uo_out=0x00, cout=1, ovf=0. Then A=0x7F, B=0x00, cin=1 → uo_out=0x80, cout=0, ovf=1.
- Pulse load_a=1 with ui_in=0x11, and separately pulse start, while busy during the 0x5A+0x3C run → result is still 0x96, and no second done pulse follows.
- Drop rst_n for one cycle at the 4th busy cycle → immediately uo_out=0x00, uio_out=0x00, busy=0. A following 0x01+0x02 run gives 0x03.
- load_a and start high in the same IDLE cycle → A loads and busy stays 0. start on the next cycle runs normally.
- With SUMADOR_SERIE_SUB_EN: A=0x10, B=0x20, sub=1 → uo_out=0xF0, cout=0, ovf=0. A=0x80, B=0x01, sub=1 → uo_out=0x7F, cout=1, ovf=1.
